pe_array_ctrl: RTL and testbench
================================

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 OUT_CHANNELS, 2, total output channels the array computes.
REQ-002 PE_ARRAY_ROW_SIZE, 2, output channels produced per phase; PHASES = OUT_CHANNELS/PE_ARRAY_ROW_SIZE.
REQ-003 NUM_WINDOWS, 16, input windows (output pixels) issued per phase.
REQ-004 PIPE_LATENCY, 12, cycles from window accept to valid array output.
REQ-005 clk  input  1  the single clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 start  input  1  one-cycle request to begin a frame.
REQ-008 abort  input  1  synchronous cancel of the current frame.
REQ-009 win_valid / win_ready  input / output  1 / 1  upstream window handshake.
REQ-010 win_idx  output  $clog2(NUM_WINDOWS)+1  index of the window offered or being accepted.
REQ-011 oc_phase  output  $clog2(OUT_CHANNELS)+1  phase index driven to the PE array.
REQ-012 transit  output  1  one-cycle phase-advance pulse to the PE array.
REQ-013 res_valid, res_win_idx, res_phase  output  1, as win_idx, as oc_phase  array output qualifier and tag.
REQ-014 busy, done  output  1, 1  frame in progress; one-cycle completion pulse.
REQ-015 stall_cycles  output  32  ISSUE cycles with win_valid low.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, DRAIN, TRANSIT, DONE.
REQ-017 IDLE: start -> ISSUE with oc_phase=0 and win_idx=0; busy=0.
REQ-018 ISSUE: win_ready=1; a window is accepted when win_valid&&win_ready, and the accept increments win_idx.
REQ-019 The accept at win_idx=NUM_WINDOWS-1 SHALL move the FSM to DRAIN and leave win_idx at 0.
REQ-020 Each accept SHALL push {1, win_idx, oc_phase} into a PIPE_LATENCY-deep tag shift register.
- No accept pushes a bubble.
- res_valid/res_win_idx/res_phase are the shift register's tail, so res_valid occurs exactly PIPE_LATENCY cycles after the accept.
REQ-021 DRAIN: win_ready=0; the FSM moves to TRANSIT in the cycle after the shift register holds no valid entry.
REQ-022 TRANSIT: transit=1 for exactly one cycle.
- If oc_phase=PHASES-1, go to DONE.
- Otherwise oc_phase increments in the next cycle and the FSM returns to ISSUE.
REQ-023 DONE: done=1 for one cycle -> IDLE; oc_phase returns to 0.
REQ-024 busy=1 in ISSUE, DRAIN, TRANSIT and DONE.
REQ-025 start is ignored while busy=1.
REQ-026 abort while busy: the next state is IDLE.
- All tags are flushed, so no further res_valid occurs.
- No transit and no done are produced.
- abort has priority over start and over any transition in the same cycle.
REQ-027 PHASES=1: one ISSUE/DRAIN/TRANSIT pass, then DONE.
REQ-028 Counter widths SHALL hold their maximum values without wrap: win_idx up to NUM_WINDOWS-1, oc_phase up to PHASES-1.

Reset
REQ-029 rst=1 SHALL force state IDLE, with every output and every tag bit at 0 on the next edge.
REQ-030 rst SHALL take priority over start and abort, including mid-frame.

Configuration
REQ-031 Macro PE_ARRAY_CTRL_PERF_CNT_EN defined: stall_cycles behaves as follows.
- It clears to 0 on an accepted start.
- It increments in each ISSUE cycle with win_valid=0.
- It saturates at 0xFFFFFFFF.
- It holds its value after done.
REQ-032 Macro PE_ARRAY_CTRL_PERF_CNT_EN undefined: stall_cycles is constant 0 and no counter logic is synthesized.

Verification (OUT_CHANNELS=4, PE_ARRAY_ROW_SIZE=2, NUM_WINDOWS=4, PIPE_LATENCY=12 unless stated)
REQ-033 Basic frame: start at cycle 0, win_valid held 1.
- Accepts occur at cycles 1-4 (phase 0) and 18-21 (phase 1).
- res_valid occurs at cycles 13-16 and 30-33.
- transit pulses at cycles 17 and 34.
- done pulses at cycle 35.
- oc_phase=1 from cycle 18.
REQ-034 Bubbles: win_valid=0 at cycles 2-3 of phase 0.
- Accepts occur at cycles 1, 4, 5, 6.
- res_valid occurs at cycles 13, 16, 17, 18 with res_win_idx 0, 1, 2, 3.
- stall_cycles=2 with the macro defined, 0 without it.
REQ-035 Abort: abort=1 at cycle 10 of the basic frame.
- IDLE from cycle 11.
- No res_valid, transit or done after cycle 10.
- A new start at cycle 12 reproduces REQ-033 timing offset by 12 cycles.
REQ-036 Reset mid-DRAIN: rst=1 at cycle 8 for one cycle.
- All outputs are 0 at cycle 9 and stay 0 until the next start.
REQ-037 Ignored start: start pulsed at cycles 0 and 5.
- Timing is identical to REQ-033, with a single done.
REQ-038 Single phase (OUT_CHANNELS=2):
- Accepts occur at cycles 1-4.
- transit occurs at cycle 17.
- done occurs at cycle 18.
- oc_phase stays 0 throughout.

Source files
------------

// File: rtl/pe_array_ctrl.sv
// PE array sequencer: issues NUM_WINDOWS windows per output-channel phase and tags results PIPE_LATENCY cycles later.
// Upstream is throttled via win_ready (low outside ISSUE); define PE_ARRAY_CTRL_PERF_CNT_EN for the stall counter.
module pe_array_ctrl #(
  parameter int OUT_CHANNELS      = 2,
  parameter int PE_ARRAY_ROW_SIZE = 2,
  parameter int NUM_WINDOWS       = 16,
  parameter int PIPE_LATENCY      = 12,
  localparam int PHASES = OUT_CHANNELS / PE_ARRAY_ROW_SIZE,
  localparam int WIW    = $clog2(NUM_WINDOWS) + 1,
  localparam int PHW    = $clog2(OUT_CHANNELS) + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic           win_valid,
  output logic           win_ready,
  output logic [WIW-1:0] win_idx,
  output logic [PHW-1:0] oc_phase,
  output logic           transit,
  output logic           res_valid,
  output logic [WIW-1:0] res_win_idx,
  output logic [PHW-1:0] res_phase,
  output logic           busy,
  output logic           done,
  output logic [31:0]    stall_cycles
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, TRANSIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIW-1:0]    win_idx_q, win_idx_d;
  logic [PHW-1:0]    oc_phase_q, oc_phase_d;
  logic              win_ready_q, win_ready_d;
  logic              transit_q, transit_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [PIPE_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [WIW-1:0]    tag_idx_q [PIPE_LATENCY];
  logic [WIW-1:0]    tag_idx_d [PIPE_LATENCY];
  logic [PHW-1:0]    tag_ph_q  [PIPE_LATENCY];
  logic [PHW-1:0]    tag_ph_d  [PIPE_LATENCY];
  logic              accept;

  assign accept = win_valid && win_ready_q;

  always_comb begin
    // Tag pipeline shifts every cycle; non-accept cycles insert an all-zero bubble
    for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
      tag_ph_d[i]  = tag_ph_q[i-1];
    end
    tag_v_d[0]   = accept;
    tag_idx_d[0] = accept ? win_idx_q : '0;
    tag_ph_d[0]  = accept ? oc_phase_q : '0;

    state_d    = state_q;
    win_idx_d  = win_idx_q;
    oc_phase_d = oc_phase_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ISSUE;
          win_idx_d  = '0;
          oc_phase_d = '0;
        end
      end
      ISSUE: begin
        if (accept) begin
          if (win_idx_q == WIW'(NUM_WINDOWS - 1)) begin
            win_idx_d = '0;
            state_d   = DRAIN;
          end else begin
            win_idx_d = win_idx_q + WIW'(1);
          end
        end
      end
      DRAIN: begin
        if (tag_v_d == '0) state_d = TRANSIT;
      end
      TRANSIT: begin
        if (oc_phase_q == PHW'(PHASES - 1)) begin
          state_d = DONE;
        end else begin
          oc_phase_d = oc_phase_q + PHW'(1);
          state_d    = ISSUE;
        end
      end
      DONE: begin
        state_d    = IDLE;
        oc_phase_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every transition and discards in-flight tags
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      win_idx_d  = '0;
      oc_phase_d = '0;
      tag_v_d    = '0;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_idx_d[i] = '0;
        tag_ph_d[i]  = '0;
      end
    end

    win_ready_d = (state_d == ISSUE);
    transit_d   = (state_d == TRANSIT);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_idx_q   <= '0;
      oc_phase_q  <= '0;
      win_ready_q <= 1'b0;
      transit_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tag_v_q     <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_idx_q[i] <= '0;
        tag_ph_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      win_idx_q   <= win_idx_d;
      oc_phase_q  <= oc_phase_d;
      win_ready_q <= win_ready_d;
      transit_q   <= transit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tag_v_q     <= tag_v_d;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        tag_idx_q[i] <= tag_idx_d[i];
        tag_ph_q[i]  <= tag_ph_d[i];
      end
    end
  end

  assign win_ready   = win_ready_q;
  assign win_idx     = win_idx_q;
  assign oc_phase    = oc_phase_q;
  assign transit     = transit_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign res_valid   = tag_v_q[PIPE_LATENCY-1];
  assign res_win_idx = tag_idx_q[PIPE_LATENCY-1];
  assign res_phase   = tag_ph_q[PIPE_LATENCY-1];

`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (state_q == ISSUE && !win_valid && !abort && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Directed timing scenarios plus random traffic against a schedule-based reference model.
module tb_pe_array_ctrl;
  localparam int OC = 4, RS = 2, NW = 4, PL = 12, PH = OC / RS;
`ifdef PE_ARRAY_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, start, start1, abort, win_valid;
  logic win_ready, transit, res_valid, busy, done;
  logic [2:0] win_idx, res_win_idx, oc_phase, res_phase;
  logic [31:0] stall_cycles;
  logic win_ready1, transit1, res_valid1, busy1, done1;
  logic [2:0] win_idx1, res_win_idx1;
  logic [1:0] oc_phase1, res_phase1;
  logic [31:0] stall_cycles1;

  pe_array_ctrl #(.OUT_CHANNELS(OC), .PE_ARRAY_ROW_SIZE(RS), .NUM_WINDOWS(NW), .PIPE_LATENCY(PL)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .win_valid(win_valid),
    .win_ready(win_ready), .win_idx(win_idx), .oc_phase(oc_phase), .transit(transit),
    .res_valid(res_valid), .res_win_idx(res_win_idx), .res_phase(res_phase),
    .busy(busy), .done(done), .stall_cycles(stall_cycles));

  pe_array_ctrl #(.OUT_CHANNELS(2), .PE_ARRAY_ROW_SIZE(2), .NUM_WINDOWS(NW), .PIPE_LATENCY(PL)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .win_valid(win_valid),
    .win_ready(win_ready1), .win_idx(win_idx1), .oc_phase(oc_phase1), .transit(transit1),
    .res_valid(res_valid1), .res_win_idx(res_win_idx1), .res_phase(res_phase1),
    .busy(busy1), .done(done1), .stall_cycles(stall_cycles1));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, base = 0;

  // Reference model: frame schedule expressed as result due-times and event cycles
  typedef struct { int due; int idx; int ph; } ent_t;
  ent_t mq[$];
  bit m_act = 0, m_iss = 0;
  int m_ph = 0, m_widx = 0, m_tr = -1, m_dn = -1;
  logic [31:0] m_stall = '0;

  logic [63:0] acc_m, res_m, tr_m, dn_m, bz_m, ph1_m;
  logic [63:0] acc1_m, tr1_m, dn1_m, bz1_m, phnz1_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] b(input int i);
    return 64'd1 << i;
  endfunction

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] setb(input logic [63:0] m, input int c);
    return (c >= 0 && c < 64) ? (m | (64'd1 << c)) : m;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_act = 0; m_iss = 0; m_ph = 0; m_widx = 0; m_tr = -1; m_dn = -1; m_stall = '0;
      mq.delete();
    end else if (m_act && abort) begin
      m_act = 0; m_iss = 0; m_ph = 0; m_widx = 0; m_tr = -1; m_dn = -1;
      mq.delete();
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_iss = 1; m_ph = 0; m_widx = 0; m_stall = '0;
      end
    end else if (m_iss) begin
      if (!win_valid) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end else begin
        mq.push_back('{due: cyc + PL, idx: m_widx, ph: m_ph});
        if (m_widx == NW - 1) begin
          m_widx = 0; m_iss = 0; m_tr = cyc + PL + 1;
        end else begin
          m_widx++;
        end
      end
    end else if (cyc == m_tr) begin
      if (m_ph == PH - 1) m_dn = cyc + 1;
      else begin m_ph++; m_iss = 1; end
    end else if (cyc == m_dn) begin
      m_act = 0; m_ph = 0; m_tr = -1; m_dn = -1;
    end
    while (mq.size() > 0 && mq[0].due <= cyc) void'(mq.pop_front());
  endtask

  task automatic compare_all();
    bit ev = (mq.size() > 0 && mq[0].due == cyc);
    chk("busy", 64'(busy), 64'(m_act));
    chk("win_ready", 64'(win_ready), 64'(m_iss));
    chk("win_idx", 64'(win_idx), 64'(m_widx));
    chk("oc_phase", 64'(oc_phase), 64'(m_ph));
    chk("transit", 64'(transit), 64'(m_act && !m_iss && cyc == m_tr));
    chk("done", 64'(done), 64'(m_act && cyc == m_dn));
    chk("res_valid", 64'(res_valid), 64'(ev));
    chk("res_win_idx", 64'(res_win_idx), ev ? 64'(mq[0].idx) : 64'd0);
    chk("res_phase", 64'(res_phase), ev ? 64'(mq[0].ph) : 64'd0);
    chk("stall_cycles", 64'(stall_cycles), PERF ? 64'(m_stall) : 64'd0);
  endtask

  task automatic tick();
    if (win_valid && win_ready)  acc_m  = setb(acc_m, cyc - base);
    if (win_valid && win_ready1) acc1_m = setb(acc1_m, cyc - base);
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_all();
    if (res_valid)      res_m   = setb(res_m, cyc - base);
    if (transit)        tr_m    = setb(tr_m, cyc - base);
    if (done)           dn_m    = setb(dn_m, cyc - base);
    if (busy)           bz_m    = setb(bz_m, cyc - base);
    if (oc_phase == 1)  ph1_m   = setb(ph1_m, cyc - base);
    if (transit1)       tr1_m   = setb(tr1_m, cyc - base);
    if (done1)          dn1_m   = setb(dn1_m, cyc - base);
    if (busy1)          bz1_m   = setb(bz1_m, cyc - base);
    if (oc_phase1 != 0) phnz1_m = setb(phnz1_m, cyc - base);
  endtask

  task automatic run(input int len, input logic [63:0] st, input logic [63:0] ab,
                     input logic [63:0] rs, input logic [63:0] bub, input bit one);
    base = cyc;
    acc_m = '0; res_m = '0; tr_m = '0; dn_m = '0; bz_m = '0; ph1_m = '0;
    acc1_m = '0; tr1_m = '0; dn1_m = '0; bz1_m = '0; phnz1_m = '0;
    for (int r = 0; r < len; r++) begin
      start     = one ? 1'b0 : st[r];
      start1    = one ? st[r] : 1'b0;
      abort     = ab[r];
      rst       = rs[r];
      win_valid = !bub[r];
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; abort = 1'b0; win_valid = 1'b0;
    tick();
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    rst = 1'b0;
    tick();

    // Basic two-phase frame
    run(40, b(0), '0, '0, '0, 1'b0);
    chk("basic_accepts", acc_m, rng(1, 4) | rng(18, 21));
    chk("basic_res", res_m, rng(13, 16) | rng(30, 33));
    chk("basic_transit", tr_m, b(17) | b(34));
    chk("basic_done", dn_m, b(35));
    chk("basic_busy", bz_m, rng(1, 35));
    chk("basic_phase1", ph1_m, rng(18, 35));

    // Bubbles in phase 0
    run(42, b(0), '0, '0, b(2) | b(3), 1'b0);
    chk("bub_accepts", acc_m, b(1) | rng(4, 6) | rng(20, 23));
    chk("bub_res", res_m, b(13) | rng(16, 18) | rng(32, 35));
    chk("bub_transit", tr_m, b(19) | b(36));
    chk("bub_done", dn_m, b(37));
    chk("bub_stall", 64'(stall_cycles), PERF ? 64'd2 : 64'd0);

    // Abort then restart
    run(52, b(0) | b(12), b(10), '0, '0, 1'b0);
    chk("abort_accepts", acc_m, rng(1, 4) | rng(13, 16) | rng(30, 33));
    chk("abort_res", res_m, rng(25, 28) | rng(42, 45));
    chk("abort_transit", tr_m, b(29) | b(46));
    chk("abort_done", dn_m, b(47));
    chk("abort_busy", bz_m, rng(1, 10) | rng(13, 47));

    // Reset mid-drain
    run(30, b(0), '0, b(8), '0, 1'b0);
    chk("rst_accepts", acc_m, rng(1, 4));
    chk("rst_res", res_m, 64'd0);
    chk("rst_transit", tr_m | dn_m, 64'd0);
    chk("rst_busy", bz_m, rng(1, 8));

    // Second start while busy is ignored
    run(40, b(0) | b(5), '0, '0, '0, 1'b0);
    chk("ign_accepts", acc_m, rng(1, 4) | rng(18, 21));
    chk("ign_transit", tr_m, b(17) | b(34));
    chk("ign_done", dn_m, b(35));
    chk("ign_busy", bz_m, rng(1, 35));

    // Single-phase instance
    run(25, b(0), '0, '0, '0, 1'b1);
    chk("one_accepts", acc1_m, rng(1, 4));
    chk("one_transit", tr1_m, b(17));
    chk("one_done", dn1_m, b(18));
    chk("one_busy", bz1_m, rng(1, 18));
    chk("one_phase", phnz1_m, 64'd0);

    // Random traffic, starts, aborts and resets
    start1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 99) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      win_valid = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
